// File: rtl/rsa_io_pkg.sv
// Shared definitions for the RSA ASIP I/O stages: loader FSM states and the
// data-memory / MMIO address map.
package rsa_io_pkg;

    localparam int MEM_ADDR_W = 18;

    localparam logic [MEM_ADDR_W-1:0] MMIO_SELECTED_ADDR = 18'h3D08D;
    localparam logic [MEM_ADDR_W-1:0] MMIO_SECTOR_ADDR   = 18'h3D08E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REQ,
        ST_WRITE,
        ST_WAIT_REL,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width double-flop synchronizer for signals crossing into clk.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gpio_input_loader.sv
// Loads the input image byte-by-byte from a GPIO req/ack source into data memory.
// Optional running byte checksum enabled by defining GPIO_LOADER_CHECKSUM_EN.
module gpio_input_loader
    import rsa_io_pkg::*;
#(
    parameter int                ADDR_W    = MEM_ADDR_W,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] IMG_BYTES = ADDR_W'(160000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              gpio_req,
    input  logic [DATA_W-1:0] gpio_data,
    output logic              gpio_ack,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    logic req_s;

    sync_2ff #(.WIDTH(1)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d_i (gpio_req),
        .q_o (req_s)
    );

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // cnt is only cleared by reset so a paused load resumes at the next address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        ack_d   = ack_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT_REQ;
            end
            ST_WAIT_REQ: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (req_s) begin
                    state_d = ST_WRITE;
                    data_d  = gpio_data;
                    addr_d  = BASE_ADDR + cnt_q;
                    wren_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_WRITE: begin
                ack_d   = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!req_s) begin
                    ack_d = 1'b0;
                    if (cnt_q == IMG_BYTES) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else if (enable) begin
                        state_d = ST_WAIT_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef GPIO_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    sum_q <= '0;
        else if (state_q == ST_WRITE) sum_q <= sum_q + data_q;
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign gpio_ack    = ack_q;
    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign mem_wren    = wren_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_gpio_input_loader.sv
// Scoreboard bench for gpio_input_loader: two instances (base 0 / 4 bytes, base 0x100 / 3 bytes).
module tb_gpio_input_loader;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst;
    logic        en_a, en_b, req_a, req_b;
    logic [7:0]  gd_a, gd_b;
    logic        ack_a, ack_b, wren_a, wren_b, busy_a, busy_b, done_a, done_b;
    logic [17:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b, ck_a, ck_b;

    gpio_input_loader #(.BASE_ADDR(18'h00000), .IMG_BYTES(18'd4)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .gpio_req(req_a), .gpio_data(gd_a),
        .gpio_ack(ack_a), .mem_address(addr_a), .mem_data(data_a), .mem_wren(wren_a),
        .busy(busy_a), .done(done_a), .checksum(ck_a)
    );

    gpio_input_loader #(.BASE_ADDR(18'h00100), .IMG_BYTES(18'd3)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .gpio_req(req_b), .gpio_data(gd_b),
        .gpio_ack(ack_b), .mem_address(addr_b), .mem_data(data_b), .mem_wren(wren_b),
        .busy(busy_b), .done(done_b), .checksum(ck_b)
    );

    typedef struct packed {
        logic [17:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   tests = 0;
    int   fails = 0;
    int   wr_a  = 0;
    int   wr_b  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wren_a === 1'b1) begin
            wr_a++;
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wr_a_unexpected: got write %0h<=%0h expected none", addr_a, data_a);
            end else begin
                ea = q_a.pop_front();
                chk("wr_a_addr", 32'(addr_a), 32'(ea.a));
                chk("wr_a_data", 32'(data_a), 32'(ea.d));
            end
        end
    end

    always @(negedge clk) begin
        if (wren_b === 1'b1) begin
            wr_b++;
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wr_b_unexpected: got write %0h<=%0h expected none", addr_b, data_b);
            end else begin
                eb = q_b.pop_front();
                chk("wr_b_addr", 32'(addr_b), 32'(eb.a));
                chk("wr_b_data", 32'(data_b), 32'(eb.d));
                chk("wr_b_busy", 32'(busy_b), 32'd1);
            end
        end
    end

    function automatic logic wren_of(input bit s);
        return s ? wren_b : wren_a;
    endfunction

    function automatic logic ack_of(input bit s);
        return s ? ack_b : ack_a;
    endfunction

    // One full 4-phase handshake; hold = extra cycles req stays high after ack.
    task automatic hs(input bit s, input logic [7:0] d, input int hold, input logic [17:0] exp_addr);
        int n;
        bit bad;
        if (s) q_b.push_back({exp_addr, d});
        else   q_a.push_back({exp_addr, d});
        @(posedge clk); #1;
        if (s) begin req_b = 1'b1; gd_b = d; end
        else   begin req_a = 1'b1; gd_a = d; end
        n = 0;
        while (wren_of(s) !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        chk("wren_latency", 32'(n), 32'd3);
        @(posedge clk); #1;
        chk("ack_rise", 32'(ack_of(s)), 32'd1);
        bad = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (ack_of(s) !== 1'b1) bad = 1'b1;
        end
        if (hold > 0) chk("ack_hold", 32'(bad), 32'd0);
        if (s) req_b = 1'b0; else req_a = 1'b0;
        n = 0;
        while (ack_of(s) !== 1'b0 && n < 10) begin @(posedge clk); #1; n++; end
        chk("ack_fall_latency", 32'(n), 32'd3);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_ck;
        bit         acked;
        int         n;
`ifdef GPIO_LOADER_CHECKSUM_EN
        exp_ck = 8'h0A;
`else
        exp_ck = 8'h00;
`endif
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; req_a = 1'b0; req_b = 1'b0;
        gd_a = 8'h00; gd_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",  32'(ack_a),  32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_wren", 32'(wren_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_ck",   32'(ck_a),   32'd0);
        @(negedge clk); rst = 1'b0;

        // Instance B: base 0x100, three bytes, busy held between bytes.
        en_b = 1'b1;
        hs(1'b1, 8'h10, 0, 18'h100);
        chk("b_busy_mid1", 32'(busy_b), 32'd1);
        hs(1'b1, 8'h20, 0, 18'h101);
        chk("b_busy_mid2", 32'(busy_b), 32'd1);
        hs(1'b1, 8'h30, 0, 18'h102);
        repeat (2) @(posedge clk);
        #1;
        chk("b_done", 32'(done_b), 32'd1);
        chk("b_busy_end", 32'(busy_b), 32'd0);
        chk("b_writes", 32'(wr_b), 32'd3);

        // Instance A: single byte A5 at address 0.
        en_a = 1'b1;
        hs(1'b0, 8'hA5, 0, 18'h0);
        chk("a_single_writes", 32'(wr_a), 32'd1);
        @(posedge clk); #1 rst = 1'b1; #2 rst = 1'b0;

        // Four bytes with an enable pause after the second.
        hs(1'b0, 8'h01, 0, 18'h0);
        hs(1'b0, 8'h02, 0, 18'h1);
        en_a = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("pause_busy", 32'(busy_a), 32'd1);
        chk("pause_done", 32'(done_a), 32'd0);
        en_a = 1'b1;
        hs(1'b0, 8'h03, 0, 18'h2);
        hs(1'b0, 8'h04, 0, 18'h3);
        repeat (2) @(posedge clk);
        #1;
        chk("a_done", 32'(done_a), 32'd1);
        chk("a_busy_end", 32'(busy_a), 32'd0);
        chk("a_checksum", 32'(ck_a), 32'(exp_ck));

        // A fifth request after DONE must be ignored.
        req_a = 1'b1; gd_a = 8'h55;
        acked = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (ack_a) acked = 1'b1; end
        req_a = 1'b0;
        chk("post_done_ack", 32'(acked), 32'd0);
        chk("post_done_writes", 32'(wr_a), 32'd5);

        // Reset while waiting for release.
        @(posedge clk); #1 rst = 1'b1; #2 rst = 1'b0;
        q_a.push_back({18'h0, 8'h11});
        @(posedge clk); #1;
        req_a = 1'b1; gd_a = 8'h11;
        n = 0;
        while (ack_a !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        chk("rel_ack_seen", 32'(ack_a), 32'd1);
        #3 rst = 1'b1; req_a = 1'b0;
        #1;
        chk("async_rst_ack",  32'(ack_a),  32'd0);
        chk("async_rst_busy", 32'(busy_a), 32'd0);
        chk("async_rst_wren", 32'(wren_a), 32'd0);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        hs(1'b0, 8'h22, 0, 18'h0);
        chk("after_rst_writes", 32'(wr_a), 32'd7);

        // Long request: exactly one write, ack held until release.
        hs(1'b0, 8'h33, 50, 18'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("long_req_writes", 32'(wr_a), 32'd8);
        chk("q_a_drained", 32'(q_a.size()), 32'd0);
        chk("q_b_drained", 32'(q_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
